// File: rtl/game_pkg.sv
// Shared VGA 640x480 timing constants, coordinate widths and colour type for the game display path.
package game_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned POS_W = 10;
    localparam int unsigned CNT_W = 10;

    typedef logic [11:0] rgb_t;

    // Square of an 11-bit signed distance; |d| never exceeds 1023 on this raster.
    function automatic logic [19:0] sq_abs(input logic signed [10:0] d);
        logic [10:0] a;
        logic [20:0] ae;
        a  = (d < 0) ? 11'(-d) : 11'(d);
        ae = {10'd0, a};
        return 20'(ae * ae);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA pixel/line counters with raw (unregistered) sync and visible-area decode.
module vga_timing
    import game_pkg::*;
#(
    parameter int unsigned H_VIS   = H_VISIBLE,
    parameter int unsigned H_FRONT = H_FP,
    parameter int unsigned H_PULSE = H_SYNC,
    parameter int unsigned H_BACK  = H_BP,
    parameter int unsigned V_VIS   = V_VISIBLE,
    parameter int unsigned V_FRONT = V_FP,
    parameter int unsigned V_PULSE = V_SYNC,
    parameter int unsigned V_BACK  = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             visible,
    output logic             hs_raw,
    output logic             vs_raw
);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_VIS + H_FRONT + H_PULSE + H_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FRONT + H_PULSE);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_VIS + V_FRONT + V_PULSE + V_BACK - 1);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FRONT + V_PULSE);

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_en) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    assign h_cnt   = h_q;
    assign v_cnt   = v_q;
    assign visible = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign hs_raw  = !((h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI));
    assign vs_raw  = !((v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI));

endmodule

// File: rtl/player_renderer.sv
// Renders both team players as filled discs over the pitch colour on a VGA raster.
// Optional collision reporting is built when PLAYER_COLLISION_EN is defined.
module player_renderer
    import game_pkg::*;
#(
    parameter int unsigned PLAYER_RADIUS = 10,
    parameter int unsigned TEAM1_HOR_POS = 80,
    parameter int unsigned TEAM2_HOR_POS = 560,
    parameter rgb_t        TEAM1_COLOR   = 12'hF00,
    parameter rgb_t        TEAM2_COLOR   = 12'h00F,
    parameter rgb_t        BG_COLOR      = 12'h0A0,
    parameter int unsigned H_VIS         = H_VISIBLE,
    parameter int unsigned H_FRONT       = H_FP,
    parameter int unsigned H_PULSE       = H_SYNC,
    parameter int unsigned H_BACK        = H_BP,
    parameter int unsigned V_VIS         = V_VISIBLE,
    parameter int unsigned V_FRONT       = V_FP,
    parameter int unsigned V_PULSE       = V_SYNC,
    parameter int unsigned V_BACK        = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic [POS_W-1:0] team1_ver_position,
    input  logic [POS_W-1:0] team2_ver_position,
    output logic             hsync,
    output logic             vsync,
    output rgb_t             rgb,
    output logic             frame_start
`ifdef PLAYER_COLLISION_EN
    ,
    output logic             collision
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FRONT + H_PULSE + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FRONT + V_PULSE + V_BACK - 1);
    localparam logic signed [10:0] T1_X = 11'(TEAM1_HOR_POS);
    localparam logic signed [10:0] T2_X = 11'(TEAM2_HOR_POS);
    localparam logic [20:0]        R_SQ = 21'(PLAYER_RADIUS * PLAYER_RADIUS);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible;
    logic             hs_raw;
    logic             vs_raw;

    vga_timing #(
        .H_VIS   (H_VIS),
        .H_FRONT (H_FRONT),
        .H_PULSE (H_PULSE),
        .H_BACK  (H_BACK),
        .V_VIS   (V_VIS),
        .V_FRONT (V_FRONT),
        .V_PULSE (V_PULSE),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw)
    );

    logic             frame_end;
    logic [POS_W-1:0] pos1_q;
    logic [POS_W-1:0] pos2_q;
    // Cleared by reset so nothing is drawn until real positions have been latched.
    logic             valid_q;
    logic             hsync_q;
    logic             vsync_q;
    rgb_t             rgb_q;
    rgb_t             rgb_d;
    logic signed [10:0] dx1, dy1, dx2, dy2;
    logic             hit1, hit2;

    assign frame_end = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_comb begin
        dx1  = $signed({1'b0, h_cnt}) - T1_X;
        dy1  = $signed({1'b0, v_cnt}) - $signed({1'b0, pos1_q});
        dx2  = $signed({1'b0, h_cnt}) - T2_X;
        dy2  = $signed({1'b0, v_cnt}) - $signed({1'b0, pos2_q});
        hit1 = ({1'b0, sq_abs(dx1)} + {1'b0, sq_abs(dy1)}) <= R_SQ;
        hit2 = ({1'b0, sq_abs(dx2)} + {1'b0, sq_abs(dy2)}) <= R_SQ;
        rgb_d = '0;
        if (visible && valid_q) begin
            if (hit1) begin
                rgb_d = TEAM1_COLOR;
            end else if (hit2) begin
                rgb_d = TEAM2_COLOR;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos1_q  <= '0;
            pos2_q  <= '0;
            valid_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else if (pix_en) begin
            hsync_q <= hs_raw;
            vsync_q <= vs_raw;
            rgb_q   <= rgb_d;
            if (frame_end) begin
                pos1_q  <= team1_ver_position;
                pos2_q  <= team2_ver_position;
                valid_q <= 1'b1;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_end;

`ifdef PLAYER_COLLISION_EN
    logic flag_q;
    logic collision_q;

    // Reports the frame just finished; the last pixel is never visible, so no overlap is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q      <= 1'b0;
            collision_q <= 1'b0;
        end else if (pix_en) begin
            if (frame_end) begin
                collision_q <= flag_q;
                flag_q      <= 1'b0;
            end else if (visible && valid_q && hit1 && hit2) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign collision = collision_q;
`endif

endmodule
